// File: rtl/prio_dual_arbiter_pkg.sv
// Shared types and helpers for the dual-channel priority arbiter.
package prio_arb_pkg;

  localparam int N_REQ = 10;
  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] CODE_NONE = '0;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } chan_state_t;

  // Grant code (index+1, 0 = none) to one-hot requester vector.
  function automatic logic [N_REQ-1:0] code2onehot(input logic [IDX_W-1:0] code);
    logic [N_REQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (code == IDX_W'(i + 1)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/prio_dual_arbiter_if.sv
// Requester-side bundle of the dual arbiter: request/enable in, grants out.
interface prio_dual_arbiter_if;
  import prio_arb_pkg::*;

  logic             en;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_a_code;
  logic [IDX_W-1:0] gnt_b_code;
  logic             gnt_a_vld;
  logic             gnt_b_vld;
  logic             forced;

  modport master (
    output en, req,
    input  gnt, gnt_a_code, gnt_b_code, gnt_a_vld, gnt_b_vld, forced
  );

  modport slave (
    input  en, req,
    output gnt, gnt_a_code, gnt_b_code, gnt_a_vld, gnt_b_vld, forced
  );

endinterface

// File: rtl/prio_dual_arbiter_enc.sv
// Enhanced priority encoder: codes of the highest and second-highest set bits.
module enhanced_prio
  import prio_arb_pkg::*;
(
  input  logic [N_REQ-1:0] r,
  output logic [IDX_W-1:0] fst,
  output logic [IDX_W-1:0] snd
);

  // Ascending scan: each new set bit pushes the previous winner down to second.
  always_comb begin
    fst = CODE_NONE;
    snd = CODE_NONE;
    for (int i = 0; i < N_REQ; i++) begin
      if (r[i]) begin
        snd = fst;
        fst = IDX_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/prio_dual_arbiter.sv
// Two shared channels granted by fixed priority, with release handshake,
// hold-time limit and an anti-hog penalty for force-released owners.
module prio_dual_arbiter
  import prio_arb_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  prio_dual_arbiter_if.slave bus
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  chan_state_t       st_q   [2];
  chan_state_t       st_d   [2];
  logic [IDX_W-1:0]  code_q [2];
  logic [IDX_W-1:0]  code_d [2];
  logic [HOLD_W-1:0] hold_q [2];
  logic [HOLD_W-1:0] hold_d [2];
  logic [N_REQ-1:0]  pen_q, pen_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              forced_q, forced_d;

  logic [N_REQ-1:0]  held, eligible, pref, cand;
  logic [IDX_W-1:0]  fst, snd;

  // Owners currently holding a channel are masked out so nobody owns both.
  always_comb begin
    held = '0;
    for (int c = 0; c < 2; c++) begin
      if (st_q[c] == GRANT) held = held | code2onehot(code_q[c]);
    end
  end

  assign eligible = bus.req & ~held;
  assign pref     = eligible & ~pen_q;
  assign cand     = (pref != '0) ? pref : eligible;

  enhanced_prio u_enc (
    .r   (cand),
    .fst (fst),
    .snd (snd)
  );

  // Next state: release/force of held channels, then new grants on idle ones.
  always_comb begin
    pen_d    = pen_q & bus.req;
    forced_d = 1'b0;
    for (int c = 0; c < 2; c++) begin
      st_d[c]   = st_q[c];
      code_d[c] = code_q[c];
      hold_d[c] = hold_q[c];
      if (st_q[c] == GRANT) begin
        if ((bus.req & code2onehot(code_q[c])) == '0) begin
          st_d[c]   = IDLE;
          code_d[c] = CODE_NONE;
          hold_d[c] = '0;
        end else if (hold_q[c] == HOLD_W'(MAX_HOLD)) begin
          st_d[c]   = IDLE;
          code_d[c] = CODE_NONE;
          hold_d[c] = '0;
          pen_d     = pen_d | code2onehot(code_q[c]);
          forced_d  = 1'b1;
        end else begin
          hold_d[c] = hold_q[c] + 1'b1;
        end
      end
    end

    if (bus.en && (cand != '0)) begin
      if (st_q[0] == IDLE) begin
        st_d[0]   = GRANT;
        code_d[0] = fst;
        hold_d[0] = HOLD_W'(1);
        pen_d     = pen_d & ~code2onehot(fst);
        if ((st_q[1] == IDLE) && (snd != CODE_NONE)) begin
          st_d[1]   = GRANT;
          code_d[1] = snd;
          hold_d[1] = HOLD_W'(1);
          pen_d     = pen_d & ~code2onehot(snd);
        end
      end else if (st_q[1] == IDLE) begin
        st_d[1]   = GRANT;
        code_d[1] = fst;
        hold_d[1] = HOLD_W'(1);
        pen_d     = pen_d & ~code2onehot(fst);
      end
    end

    gnt_d = code2onehot(code_d[0]) | code2onehot(code_d[1]);
  end

  // Registered channel state, penalty vector and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        st_q[c]   <= IDLE;
        code_q[c] <= CODE_NONE;
        hold_q[c] <= '0;
      end
      pen_q    <= '0;
      gnt_q    <= '0;
      forced_q <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        st_q[c]   <= st_d[c];
        code_q[c] <= code_d[c];
        hold_q[c] <= hold_d[c];
      end
      pen_q    <= pen_d;
      gnt_q    <= gnt_d;
      forced_q <= forced_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.gnt_a_code = code_q[0];
  assign bus.gnt_b_code = code_q[1];
  assign bus.gnt_a_vld  = (st_q[0] == GRANT);
  assign bus.gnt_b_vld  = (st_q[1] == GRANT);
  assign bus.forced     = forced_q;

endmodule

// File: doc/prio_dual_arbiter.md
Name: prio_dual_arbiter

Overview:
Shares two identical service channels (A, B) among 10 requesters using the fixed-priority enhanced encoding: highest bit index wins, and a grant code is index+1 (0 = none). The block wraps the enhanced_prio encoder (fst/snd) with registered grant ownership, release handshake and a hold-time limit with anti-hog penalty. It sits between requesters and two shared datapath ports and drives their select lines.

Parameters:
N_REQ, 10, number of requesters (bit 9 highest priority)
IDX_W, 4, width of grant code (index+1, 0 = none)
MAX_HOLD, 15, maximum consecutive cycles a channel may be held (>=2)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  1 = new grants allowed; 0 = freeze new grants, held grants continue
req  in  N_REQ  request vector; held high while requester uses a channel
gnt  out  N_REQ  grant vector, OR of both channel owners (at most 2 bits set)
gnt_a_code  out  IDX_W  channel A owner code (index+1), 0 when idle
gnt_b_code  out  IDX_W  channel B owner code, 0 when idle
gnt_a_vld  out  1  channel A in GRANT
gnt_b_vld  out  1  channel B in GRANT
forced  out  1  one-cycle pulse: a channel was force-released this cycle

Behaviour:
- Reset (async, rst_n=0): both channels IDLE, codes 0, vld 0, gnt 0, forced 0, hold counters 0, penalty vector 0.
- Per-channel FSM: IDLE, GRANT. All outputs registered; a request sampled at edge t yields a grant visible after edge t+1 (1-cycle latency).
- held = owner bits of channels in GRANT. eligible = req & ~held. pref = eligible & ~penalty; cand = (pref != 0) ? pref : eligible.
- Encoder inputs cand; fst = highest set bit code, snd = second highest.
- Both channels IDLE, en=1: A <- fst, B <- snd (each only if nonzero). One candidate: A only.
- Only A IDLE: A <- fst. Only B IDLE: B <- fst. Both GRANT or en=0 or cand=0: no change.
- IDLE->GRANT: code loaded, vld=1, hold counter=1; penalty[owner] cleared.
- GRANT->IDLE (release): req[owner]=0 sampled -> next cycle IDLE, code 0. No same-cycle regrant on the freed channel; it arbitrates on the following cycle (1 bubble).
- GRANT->IDLE (forced): hold counter == MAX_HOLD with req[owner] still 1 -> IDLE, penalty[owner]=1, forced=1 for that cycle. Release takes precedence over force when both apply.
- Hold counter saturates at MAX_HOLD; counts cycles in GRANT.
- penalty[i] clears when req[i]=0 or when i is granted. Penalized requesters still win if no unpenalized requester is eligible (no idle waste).
- A requester never owns both channels (held masked).
- Both channels forced in same cycle: forced=1 single pulse, both penalty bits set.
- en low while held: hold counting and release/force continue.
- Reset mid-grant: immediate async clear; no pulse on forced.

Decomposition:
- Package prio_arb_pkg: N_REQ, IDX_W, CODE_NONE = 0, chan_state_t {IDLE, GRANT}, function code2onehot.
- Sub-module: existing enhanced_prio (combinational r[9:0] -> fst/snd). Instantiate it once, with cand as input. Channel FSM + counter written inline ×2 (generate or duplicated always blocks).

Test Plan:
- Reset/idle: rst_n=0 then req=0 -> all outputs 0 for 5 cycles; en=1 with req=0 -> still no grants.
- Dual grant: req=10'b0000101001 -> after 1 cycle gnt_a_code=6 (bit5), gnt_b_code=4 (bit3), gnt=10'b0000101000; bit0 waits.
- Release/bubble: from previous state, drop req[5] -> next cycle A idle (code 0). Following cycle A code=1 (bit0). B unchanged at 4.
- Force/penalty, MAX_HOLD=15: req=10'b1000000001 held -> A=10, B=1. After 15 GRANT cycles both forced (forced=1 once). One idle cycle follows. With no unpenalized requester, A=10, B=1 are regranted.
- Penalty preference: A forced off bit9 while req[7] newly high -> next grant A=8 (bit7), not 10. Bit9 granted after 7 releases.
- en gating + async reset: en=0, req=10'b1111111111 -> no grants. en=1 -> A=10, B=9. Assert rst_n=0 mid-cycle -> gnt=0 immediately, before the next clock edge.
